// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: stage state encoding,
// occupancy width and the state-to-occupancy mapping.
package pipe_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_SKIDDED
  } state_e;

  function automatic logic [OCC_W-1:0] occ_of(input state_e st);
    case (st)
      ST_FULL:    occ_of = OCC_W'(1);
      ST_SKIDDED: occ_of = OCC_W'(2);
      default:    occ_of = '0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One holding entry of the stage: a valid bit plus payload, with load,
// clear and optional zero-on-empty payload.
module pipe_stage_slot #(
  parameter int unsigned WIDTH           = 128,
  parameter int unsigned CLEAR_ON_BUBBLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // clear wins over load so a flush discards a beat arriving the same cycle
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      if (CLEAR_ON_BUBBLE != 0) data_d = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register: optional 2-entry skid buffer with a
// registered in_ready, or a single register with a combinational ready path.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH           = 128,
  parameter int unsigned SKID            = 1,
  parameter int unsigned CLEAR_ON_BUBBLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  state_e           state_q, state_d;
  logic [OCC_W-1:0] occ_q;
  logic             in_xfer, out_xfer;
  logic             main_load, main_clear, skid_load, skid_clear;
  logic [WIDTH-1:0] main_data_d, skid_data;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_load   = 1'b0;
    main_clear  = 1'b0;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    main_data_d = in_data;
    if (flush) begin
      state_d    = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d   = ST_FULL;
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (out_xfer) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
          end else if (in_xfer && SKID != 0) begin
            state_d   = ST_SKIDDED;
            skid_load = 1'b1;
          end
        end
        ST_SKIDDED: begin
          // in_ready is low here, so only the skid beat can advance
          main_data_d = skid_data;
          if (out_xfer) begin
            state_d    = ST_FULL;
            main_load  = 1'b1;
            skid_clear = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_of(state_d);
    end
  end

  pipe_stage_slot #(
    .WIDTH          (WIDTH),
    .CLEAR_ON_BUBBLE(CLEAR_ON_BUBBLE)
  ) u_main (
    .clk_i  (clk),
    .rst_i  (rst),
    .clear_i(main_clear),
    .load_i (main_load),
    .data_i (main_data_d),
    .valid_o(out_valid),
    .data_o (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;
      logic skid_valid;

      pipe_stage_slot #(
        .WIDTH          (WIDTH),
        .CLEAR_ON_BUBBLE(CLEAR_ON_BUBBLE)
      ) u_skid (
        .clk_i  (clk),
        .rst_i  (rst),
        .clear_i(skid_clear),
        .load_i (skid_load),
        .data_i (in_data),
        .valid_o(skid_valid),
        .data_o (skid_data)
      );

      always_ff @(posedge clk) begin
        if (rst) in_ready_q <= 1'b1;
        else     in_ready_q <= (state_d != ST_SKIDDED);
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign skid_data = '0;
      assign in_ready  = out_ready | ~out_valid;
    end
  endgenerate

  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a skid (SKID=1) and a non-skid (SKID=0) stage with shared stimulus and
// compares both against a FIFO-of-beats reference model every cycle.
module tb_pipe_stage_reg;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [31:0] out_data1, out_data0;
  logic [1:0]  occ1, occ0;

  logic [31:0] q1[$];
  logic [31:0] q0[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .SKID(1), .CLEAR_ON_BUBBLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .occupancy(occ1)
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(0), .CLEAR_ON_BUBBLE(1)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .occupancy(occ0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs after the falling edge, compare against the model,
  // then advance the model to what the rising edge should produce.
  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [31:0] d, input logic ordy);
    logic        exp_rdy1, exp_rdy0, acc1, acc0;
    logic [31:0] head1, head0;
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    head1    = (q1.size() > 0) ? q1[0] : 32'h0;
    head0    = (q0.size() > 0) ? q0[0] : 32'h0;
    exp_rdy1 = (q1.size() < 2);
    exp_rdy0 = ordy || (q0.size() == 0);
    chk("s1_valid", {31'b0, out_valid1}, {31'b0, q1.size() > 0});
    chk("s1_data",  out_data1, head1);
    chk("s1_ready", {31'b0, in_ready1}, {31'b0, exp_rdy1});
    chk("s1_occ",   {30'b0, occ1}, q1.size());
    chk("s0_valid", {31'b0, out_valid0}, {31'b0, q0.size() > 0});
    chk("s0_data",  out_data0, head0);
    chk("s0_ready", {31'b0, in_ready0}, {31'b0, exp_rdy0});
    chk("s0_occ",   {30'b0, occ0}, q0.size());
    acc1 = iv && exp_rdy1;
    acc0 = iv && exp_rdy0;
    if (r) begin
      q1.delete(); q0.delete();
    end else begin
      if (q1.size() > 0 && ordy) void'(q1.pop_front());
      if (q0.size() > 0 && ordy) void'(q0.pop_front());
      if (f) begin
        q1.delete(); q0.delete();
      end else begin
        if (acc1) q1.push_back(d);
        if (acc0) q0.push_back(d);
      end
    end
  endtask

  // Look at the skid stage just after the rising edge, against fixed values.
  task automatic peek(input string tag, input logic v, input logic [31:0] d,
                      input logic [1:0] occ, input logic rdy);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, {31'b0, out_valid1}, {31'b0, v});
    chk({tag, "_data"},  out_data1, d);
    chk({tag, "_occ"},   {30'b0, occ1}, {30'b0, occ});
    chk({tag, "_ready"}, {31'b0, in_ready1}, {31'b0, rdy});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // streaming
    cycle(0, 0, 1, 32'h1, 1); peek("stream1", 1, 32'h1, 1, 1);
    cycle(0, 0, 1, 32'h2, 1); peek("stream2", 1, 32'h2, 1, 1);
    cycle(0, 0, 1, 32'h3, 1); peek("stream3", 1, 32'h3, 1, 1);
    cycle(0, 0, 0, 32'h0, 1); peek("drained", 0, 32'h0, 0, 1);

    // stall fills the skid, then drains in order
    cycle(0, 0, 1, 32'hA, 0);
    cycle(0, 0, 1, 32'hB, 0); peek("stall", 1, 32'hA, 2, 0);
    cycle(0, 0, 0, 32'h0, 1); peek("unstall", 1, 32'hB, 1, 1);
    cycle(0, 0, 0, 32'h0, 1); peek("unstall_empty", 0, 32'h0, 0, 1);

    // flush of a full skid with a beat arriving
    cycle(0, 0, 1, 32'h5, 0);
    cycle(0, 0, 1, 32'h6, 0);
    cycle(0, 1, 1, 32'h7, 0); peek("flush", 0, 32'h0, 0, 1);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);

    // reset mid-stream
    cycle(0, 0, 1, 32'h8, 0);
    cycle(0, 0, 1, 32'h9, 0);
    cycle(1, 0, 0, 32'h0, 0); peek("reset", 0, 32'h0, 0, 1);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);

    // out_ready toggling under continuous input (exercises the SKID=0 ready path)
    cycle(0, 0, 1, 32'h10, 1);
    cycle(0, 0, 1, 32'h11, 0);
    cycle(0, 0, 1, 32'h12, 1);
    cycle(0, 0, 1, 32'h13, 1);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);

    // random traffic with occasional flush and reset
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0));
    end
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
